uart_data_rx: RTL and testbench
===============================

# uart_data_rx

Multi-byte UART word receiver: deserialises standard 8N1 UART bytes from `uart_rx` and assembles DATA_WIDTH/8 consecutive bytes into one DATA_WIDTH-bit word. It presents the word with a one-cycle `Rx_Done` pulse. It is the receive-side counterpart of the multi-byte word transmitter and uses the same byte order and baud encoding, so the two can be paired directly (for example, 12-bit ADC results zero-padded to 16 bits). Framing errors and inter-byte timeouts discard the partial word and resynchronise to the next byte.

## Interface
- DATA_WIDTH, 8: word width; a multiple of 8, range 8..256.
- MSB_FIRST, 1: 1 = first received byte is the most significant byte; 0 = first received byte is the least significant byte.
- CLK_FREQ, 50_000_000: Clk frequency in Hz; used for the baud divisors.
- TIMEOUT_BITS, 20: inter-byte idle limit, in bit periods.
- Clk  in  1  clock; all logic on posedge.
- Rst_n  in  1  reset, asynchronous, active-low.
- uart_rx  in  1  serial line, asynchronous, idle high.
- Baud_Set  in  3  0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200; values 5..7 select 115200.
- data  out  DATA_WIDTH  last complete word; held until the next `Rx_Done`.
- Rx_Done  out  1  one-cycle pulse when `data` is updated.
- uart_state  out  1  high while a word is in progress.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- timeout_err  out  1  one-cycle pulse on inter-byte timeout.

## Operation
- Input synchroniser: `uart_rx` passes through 2 flops, both reset to 1. A 3rd flop provides edge detection. A start is a synced 1→0 edge detected in IDLE.
- Bit period: DIV = CLK_FREQ/baud, integer division. HALF = DIV/2. Baud_Set is latched at each start edge and held for that byte.
- Byte FSM states are IDLE, START, DATA, STOP.
  - IDLE → START on a start edge. The baud counter is cleared.
  - START: after HALF-1 cycles, sample the line. If it is low, go to DATA. If it is high, this is a false start: return to IDLE with no error pulse and no change to the word state.
  - DATA: sample every DIV cycles, 8 bits, LSB first, into the byte shift register. After bit 7, go to STOP.
  - STOP: sample after DIV cycles. If the line is 1, the byte is valid: pass it to word assembly and return to IDLE. If the line is 0, pulse `frame_err`, discard the partial word (count := 0), and return to IDLE. IDLE then waits for a synced high before accepting a new edge (break handling).
- Word assembly:
  - byte count: 0..N-1, where N = DATA_WIDTH/8.
  - shift register: word_r.
  - MSB_FIRST=1: word_r := {word_r[W-9:0], byte}.
  - MSB_FIRST=0: word_r := {byte, word_r[W-1:8]}.
  - DATA_WIDTH=8: word_r := byte.
- On the N-th valid byte: `data` := the assembled word, `Rx_Done` pulses, and count := 0.
- uart_state:
  - Set on the start edge of the first byte of a word when count = 0 (a false start clears it again).
  - Cleared on `Rx_Done`, `frame_err`, or `timeout_err`.
- Timeout:
  - The idle counter runs only while count > 0 and the FSM is in IDLE.
  - It clears on every start edge.
  - When it reaches TIMEOUT_BITS×DIV cycles: pulse `timeout_err`, set count := 0, and clear uart_state.
  - If a start edge and the expiry occur in the same cycle, the start edge wins and no timeout fires.
- `data` is never partially updated; error cases leave it unchanged.

## Timing
- Reset values:
  - `data` = 0, `Rx_Done` = 0, `frame_err` = 0, `timeout_err` = 0, `uart_state` = 0.
  - FSM = IDLE, count = 0, all counters = 0.
- Reset mid-word or mid-byte aborts silently: no pulses, and `data` returns to 0.
- Start detection latency is 3 Clk cycles from the line edge to START entry, due to the synchroniser and edge flop.
- The bit-k sample occurs HALF + (k+1)×DIV cycles after START entry. The stop sample occurs HALF + 9×DIV cycles after START entry.
- `Rx_Done`, `frame_err`, and `timeout_err` are registered: each is high exactly 1 cycle, the cycle after its deciding sample or counter terminal value.
- `data` is valid in the same cycle `Rx_Done` is high.
- Back-to-back bytes with no idle gap between the stop bit and the next start bit are accepted. The FSM is in IDLE before the next start edge arrives, because the stop sample is taken at the stop-bit centre.
- Tolerated baud mismatch is ±2% (centre sampling).

## Test plan
- CLK_FREQ=50 MHz, Baud_Set=4 (DIV=434), DATA_WIDTH=16, MSB_FIRST=1. Send bytes 0x12, 0x34 back-to-back → one `Rx_Done` with `data`=0x1234. `uart_state` is high from the first start edge to `Rx_Done`.
- Same setup with MSB_FIRST=0 → `data`=0x3412. With DATA_WIDTH=32, bytes 0xDE, 0xAD, 0xBE, 0xEF and MSB_FIRST=1 → `data`=0xDEADBEEF.
- Send 0x12, then a byte with stop bit = 0, then 0xAB, 0xCD → `frame_err` pulses once, there is no `Rx_Done` for the bad pair, then `data`=0xABCD.
- Send 0x12, then hold the line idle for 25 bit times → `timeout_err` pulses at 20×434 cycles after IDLE entry, and `data` is unchanged. Then send 0x56, 0x78 → `data`=0x5678.
- Glitch: a low pulse of 100 cycles at Baud_Set=4 → false start, no pulses, and the next word is received correctly. Baud_Set=0 (DIV=5208) with bytes 0xA5, 0x5A → `data`=0xA55A.
- Assert Rst_n low for 5 cycles midway through the 2nd byte → all outputs return to 0 with no pulses. A subsequent 0x9A, 0xBC → `data`=0x9ABC.

Source files
------------

// File: rtl/uart_data_rx_if.sv
// Signal bundle between the multi-byte UART word receiver and its user.
//   uart_rx     : serial line into the receiver, idle high
//   Baud_Set    : baud select, latched by the receiver at each start edge
//   data        : last complete word
//   Rx_Done     : one-cycle pulse when data updates
//   uart_state  : high while a word is being assembled
//   frame_err   : one-cycle pulse on a bad stop bit
//   timeout_err : one-cycle pulse when the gap between bytes of a word is too long
// The master modport is the side that drives the line; slave is the receiver.
interface uart_data_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  uart_rx;
  logic [2:0]            Baud_Set;
  logic [DATA_WIDTH-1:0] data;
  logic                  Rx_Done;
  logic                  uart_state;
  logic                  frame_err;
  logic                  timeout_err;

  modport master (
    output uart_rx, Baud_Set,
    input  data, Rx_Done, uart_state, frame_err, timeout_err
  );

  modport slave (
    input  uart_rx, Baud_Set,
    output data, Rx_Done, uart_state, frame_err, timeout_err
  );
endinterface

// File: rtl/uart_data_rx.sv
// Multi-byte UART word receiver. Deserialises 8N1 bytes from bus_io.uart_rx and assembles
// DATA_WIDTH/8 consecutive bytes into one word, presented on bus_io.data with a one-cycle
// bus_io.Rx_Done pulse. A bad stop bit or an over-long gap between bytes drops the partial
// word and the receiver resynchronises on the next start bit.
// Ports:
//   Clk    : clock, all logic on the rising edge
//   Rst_n  : asynchronous active-low reset
//   bus_io : slave side of uart_data_rx_if (line and baud select in, word and status out)
module uart_data_rx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic          Clk,
  input  logic          Rst_n,
  uart_data_rx_if.slave bus_io
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam logic [5:0]  LastByte = 6'(NumBytes - 1);

  localparam logic [31:0] Div9600   = 32'(CLK_FREQ / 9600);
  localparam logic [31:0] Div19200  = 32'(CLK_FREQ / 19200);
  localparam logic [31:0] Div38400  = 32'(CLK_FREQ / 38400);
  localparam logic [31:0] Div57600  = 32'(CLK_FREQ / 57600);
  localparam logic [31:0] Div115200 = 32'(CLK_FREQ / 115200);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q, state_d;
  logic                  rx_s1_q, rx_s2_q, rx_s3_q;
  logic [2:0]            baud_q, baud_d;
  logic [31:0]           div, half, idle_limit;
  logic [31:0]           bit_cnt_q, bit_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            byte_q, byte_d;
  logic [5:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d, word_next;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           idle_cnt_q, idle_cnt_d;
  logic                  busy_q, busy_d;
  logic                  rx_done_q, rx_done_d;
  logic                  frame_err_q, frame_err_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  start_edge;

  // Divisors follow the baud latched at the start edge, so a mid-byte change is ignored.
  always_comb begin
    div = Div115200;
    case (baud_q)
      3'd0:    div = Div9600;
      3'd1:    div = Div19200;
      3'd2:    div = Div38400;
      3'd3:    div = Div57600;
      default: div = Div115200;
    endcase
    half       = div >> 1;
    idle_limit = 32'(TIMEOUT_BITS) * div;
  end

  // Shift forms also cover DATA_WIDTH == 8, where the new word is just the byte.
  if (MSB_FIRST) begin : g_msb_first
    assign word_next = (word_q << 8) | DATA_WIDTH'(byte_q);
  end else begin : g_lsb_first
    assign word_next = (word_q >> 8) | (DATA_WIDTH'(byte_q) << (DATA_WIDTH - 8));
  end

  // A start needs a synced high-to-low transition, so a line held low after a framing
  // error (break) cannot retrigger until it has returned high.
  assign start_edge = (state_q == StIdle) && rx_s3_q && !rx_s2_q;

  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_cnt_d     = bit_cnt_q + 32'd1;
    bit_idx_d     = bit_idx_q;
    byte_d        = byte_q;
    byte_cnt_d    = byte_cnt_q;
    word_d        = word_q;
    data_d        = data_q;
    idle_cnt_d    = '0;
    busy_d        = busy_q;
    rx_done_d     = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (start_edge) begin
          // Start edge takes priority over a simultaneous timeout expiry.
          state_d = StStart;
          baud_d  = bus_io.Baud_Set;
          if (byte_cnt_q == '0) busy_d = 1'b1;
        end else if (byte_cnt_q != '0) begin
          if (idle_cnt_q == idle_limit - 32'd1) begin
            timeout_err_d = 1'b1;
            byte_cnt_d    = '0;
            busy_d        = 1'b0;
          end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
          end
        end
      end
      StStart: begin
        if (bit_cnt_q == half - 32'd1) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          if (!rx_s2_q) begin
            state_d = StData;
          end else begin
            // False start: only undo the busy flag this edge raised.
            state_d = StIdle;
            if (byte_cnt_q == '0) busy_d = 1'b0;
          end
        end
      end
      StData: begin
        if (bit_cnt_q == div - 32'd1) begin
          bit_cnt_d = '0;
          byte_d    = {rx_s2_q, byte_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (bit_cnt_q == div - 32'd1) begin
          bit_cnt_d = '0;
          state_d   = StIdle;
          if (rx_s2_q) begin
            word_d = word_next;
            if (byte_cnt_q == LastByte) begin
              data_d     = word_next;
              rx_done_d  = 1'b1;
              byte_cnt_d = '0;
              busy_d     = 1'b0;
            end else begin
              byte_cnt_d = byte_cnt_q + 6'd1;
            end
          end else begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            busy_d      = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_s3_q       <= 1'b1;
      state_q       <= StIdle;
      baud_q        <= '0;
      bit_cnt_q     <= '0;
      bit_idx_q     <= '0;
      byte_q        <= '0;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      data_q        <= '0;
      idle_cnt_q    <= '0;
      busy_q        <= 1'b0;
      rx_done_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      rx_s1_q       <= bus_io.uart_rx;
      rx_s2_q       <= rx_s1_q;
      rx_s3_q       <= rx_s2_q;
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      byte_q        <= byte_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      data_q        <= data_d;
      idle_cnt_q    <= idle_cnt_d;
      busy_q        <= busy_d;
      rx_done_q     <= rx_done_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus_io.data        = data_q;
  assign bus_io.Rx_Done     = rx_done_q;
  assign bus_io.uart_state  = busy_q;
  assign bus_io.frame_err   = frame_err_q;
  assign bus_io.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_data_rx.sv
// Bench for uart_data_rx: three receivers (16-bit MSB-first, 16-bit LSB-first, 32-bit
// MSB-first) listen to one serial line. A byte-level model predicts each receiver's words
// and error pulses; predicted words are queued and compared when Rx_Done appears.
module tb_uart_data_rx;

  localparam int unsigned ClkFreq     = 5_000_000;
  localparam int unsigned TimeoutBits = 20;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        line  = 1'b1;
  logic [2:0]  baud  = 3'd4;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_data_rx_if #(.DATA_WIDTH(16)) bus_a ();
  uart_data_rx_if #(.DATA_WIDTH(16)) bus_b ();
  uart_data_rx_if #(.DATA_WIDTH(32)) bus_c ();

  assign bus_a.uart_rx  = line;
  assign bus_b.uart_rx  = line;
  assign bus_c.uart_rx  = line;
  assign bus_a.Baud_Set = baud;
  assign bus_b.Baud_Set = baud;
  assign bus_c.Baud_Set = baud;

  uart_data_rx #(.DATA_WIDTH(16), .MSB_FIRST(1'b1), .CLK_FREQ(ClkFreq),
                 .TIMEOUT_BITS(TimeoutBits)) dut_a (.Clk(clk), .Rst_n(rst_n),
                                                    .bus_io(bus_a.slave));
  uart_data_rx #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .CLK_FREQ(ClkFreq),
                 .TIMEOUT_BITS(TimeoutBits)) dut_b (.Clk(clk), .Rst_n(rst_n),
                                                    .bus_io(bus_b.slave));
  uart_data_rx #(.DATA_WIDTH(32), .MSB_FIRST(1'b1), .CLK_FREQ(ClkFreq),
                 .TIMEOUT_BITS(TimeoutBits)) dut_c (.Clk(clk), .Rst_n(rst_n),
                                                    .bus_io(bus_c.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model state, index 0/1/2 = dut_a/dut_b/dut_c.
  int unsigned nbytes [3] = '{2, 2, 4};
  bit          msb    [3] = '{1'b1, 1'b0, 1'b1};
  int unsigned mcount [3] = '{0, 0, 0};
  logic [31:0] mword  [3] = '{0, 0, 0};
  logic [31:0] last_w [3] = '{0, 0, 0};
  int unsigned exp_fe [3] = '{0, 0, 0};
  int unsigned exp_to [3] = '{0, 0, 0};
  int unsigned got_fe [3] = '{0, 0, 0};
  int unsigned got_to [3] = '{0, 0, 0};
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];
  int unsigned start_cyc = 0;
  int unsigned to_cyc    = 0;

  function automatic int unsigned div_of(input logic [2:0] b);
    case (b)
      3'd0:    return ClkFreq / 9600;
      3'd1:    return ClkFreq / 19200;
      3'd2:    return ClkFreq / 38400;
      3'd3:    return ClkFreq / 57600;
      default: return ClkFreq / 115200;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] mask;
    for (int i = 0; i < 3; i++) begin
      mask = (nbytes[i] == 4) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      if (msb[i]) mword[i] = (mword[i] << 8) | 32'(b);
      else        mword[i] = (mword[i] >> 8) | (32'(b) << (8 * (nbytes[i] - 1)));
      mword[i] = mword[i] & mask;
      mcount[i]++;
      if (mcount[i] == nbytes[i]) begin
        mcount[i] = 0;
        last_w[i] = mword[i];
        case (i)
          0:       q_a.push_back(mword[i]);
          1:       q_b.push_back(mword[i]);
          default: q_c.push_back(mword[i]);
        endcase
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    int unsigned d;
    d = div_of(baud);
    line      = 1'b0;
    start_cyc = cyc;
    repeat (d) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      line = b[k];
      repeat (d) @(negedge clk);
    end
    line = stop;
    repeat (d) @(negedge clk);
    line = 1'b1;
  endtask

  // Model first: the receiver decides at mid stop bit, before the frame finishes.
  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 1'b1);
  endtask

  task automatic send_bad_byte(input logic [7:0] b);
    for (int i = 0; i < 3; i++) begin
      mcount[i] = 0;
      exp_fe[i]++;
    end
    send_frame(b, 1'b0);
  endtask

  task automatic idle_bits(input int unsigned bits);
    line = 1'b1;
    repeat (bits * div_of(baud)) @(negedge clk);
  endtask

  task automatic check_pulses(input string tag);
    check_eq({tag, " a frame_err"}, got_fe[0], exp_fe[0]);
    check_eq({tag, " c frame_err"}, got_fe[2], exp_fe[2]);
    check_eq({tag, " a timeout"}, got_to[0], exp_to[0]);
    check_eq({tag, " b timeout"}, got_to[1], exp_to[1]);
    check_eq({tag, " c timeout"}, got_to[2], exp_to[2]);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " a uart_state"}, 32'(bus_a.uart_state), 32'd0);
    check_eq({tag, " c uart_state"}, 32'(bus_c.uart_state), 32'd0);
    check_eq({tag, " a data"}, 32'(bus_a.data), last_w[0]);
    check_eq({tag, " b data"}, 32'(bus_b.data), last_w[1]);
    check_eq({tag, " c data"}, bus_c.data, last_w[2]);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.Rx_Done) begin
        if (q_a.size() == 0) check_eq("a unexpected Rx_Done", 32'd1, 32'd0);
        else check_eq("a word", 32'(bus_a.data), q_a.pop_front());
      end
      if (bus_b.Rx_Done) begin
        if (q_b.size() == 0) check_eq("b unexpected Rx_Done", 32'd1, 32'd0);
        else check_eq("b word", 32'(bus_b.data), q_b.pop_front());
      end
      if (bus_c.Rx_Done) begin
        if (q_c.size() == 0) check_eq("c unexpected Rx_Done", 32'd1, 32'd0);
        else check_eq("c word", bus_c.data, q_c.pop_front());
      end
      if (bus_a.frame_err)   got_fe[0]++;
      if (bus_b.frame_err)   got_fe[1]++;
      if (bus_c.frame_err)   got_fe[2]++;
      if (bus_a.timeout_err) begin
        got_to[0]++;
        to_cyc = cyc;
      end
      if (bus_b.timeout_err) got_to[1]++;
      if (bus_c.timeout_err) got_to[2]++;
    end
  end

  initial begin
    int unsigned d;
    int unsigned exp_to_cyc;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset Rx_Done", 32'(bus_a.Rx_Done), 32'd0);
    check_eq("reset frame_err", 32'(bus_a.frame_err), 32'd0);
    check_eq("reset timeout_err", 32'(bus_c.timeout_err), 32'd0);
    check_idle("reset");

    // Back-to-back bytes; busy from first start edge to end of word.
    send_byte(8'h12);
    check_eq("mid-word a uart_state", 32'(bus_a.uart_state), 32'd1);
    check_eq("mid-word c uart_state", 32'(bus_c.uart_state), 32'd1);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    idle_bits(2);
    check_idle("b2b");
    check_pulses("b2b");

    // Framing error drops the partial word.
    send_byte(8'h12);
    send_bad_byte(8'h77);
    idle_bits(2);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    send_byte(8'h01);
    idle_bits(2);
    check_idle("frame");
    check_pulses("frame");

    // Inter-byte timeout, with exact pulse timing.
    d = div_of(baud);
    to_cyc = 0;
    send_byte(8'h12);
    exp_to_cyc = start_cyc + 3 + d / 2 + 9 * d + TimeoutBits * d;
    idle_bits(25);
    for (int i = 0; i < 3; i++) begin
      mcount[i] = 0;
      exp_to[i]++;
    end
    check_eq("timeout cycle", to_cyc, exp_to_cyc);
    check_idle("timeout");
    check_pulses("timeout");
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h9A);
    send_byte(8'hBC);
    idle_bits(2);
    check_idle("post-timeout");

    // Glitch shorter than half a bit is a false start.
    line = 1'b0;
    repeat (10) @(negedge clk);
    idle_bits(3);
    check_idle("glitch");
    check_pulses("glitch");
    send_byte(8'h13);
    send_byte(8'h57);
    send_byte(8'h9B);
    send_byte(8'hDF);
    idle_bits(2);
    check_idle("post-glitch");

    // Slowest baud.
    baud = 3'd0;
    idle_bits(2);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h3C);
    idle_bits(2);
    check_idle("9600");
    check_pulses("9600");
    baud = 3'd4;
    idle_bits(2);

    // Reset in the middle of the second byte.
    d = div_of(baud);
    send_byte(8'h11);
    line = 1'b0;
    repeat (d) @(negedge clk);
    line = 1'b0;
    repeat (3 * d) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mcount[i] = 0;
      mword[i]  = '0;
      last_w[i] = '0;
    end
    check_idle("in-reset");
    repeat (3) @(negedge clk);
    line  = 1'b1;
    rst_n = 1'b1;
    idle_bits(3);
    check_idle("post-reset");
    check_pulses("post-reset");
    send_byte(8'h9A);
    send_byte(8'hBC);
    send_byte(8'hDE);
    send_byte(8'hF0);
    idle_bits(2);
    check_idle("final");
    check_pulses("final");
    check_eq("a words outstanding", 32'(q_a.size()), 32'd0);
    check_eq("b words outstanding", 32'(q_b.size()), 32'd0);
    check_eq("c words outstanding", 32'(q_c.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
